// File: rtl/conv_window_gen_pkg.sv
// Shared types and the window tap layout for the sliding-window generator
// and the convolution engine that consumes its output.
package conv_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Bit offset of tap (r, c) of channel ch inside a packed window vector.
  function automatic int tap_offset(input int ch, input int r, input int c,
                                    input int k, input int n);
    return ((ch * k + r) * k + c) * n;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, window stream out; no backpressure in either direction.
interface conv_window_gen_if #(
  parameter int CL_IN  = 8,
  parameter int KERNEL = 3,
  parameter int N      = 2
);
  logic [CL_IN*N-1:0]               pix_in;
  logic                             pix_valid;
  logic                             sof;
  logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv;
  logic                             en_out;
  logic                             frame_done;
  logic                             sof_err;

  modport master (
    output pix_in, pix_valid, sof,
    input  data2conv, en_out, frame_done, sof_err
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output data2conv, en_out, frame_done, sof_err
  );
endinterface

// File: rtl/conv_window_gen_row_delay_line.sv
// One image row of delay: the output is the word written DEPTH enabled
// cycles earlier, held in a RAM addressed by a wrapping pointer.
module conv_window_gen_row_delay_line #(
  parameter int W     = 16,
  parameter int DEPTH = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  // Read-before-write at the same slot gives exactly DEPTH entries of delay.
  assign dout = mem[ptr];

  // NOTE: the storage array has no reset so it maps onto RAM; the counters
  // upstream guarantee nothing written before the frame is ever emitted.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator: line buffers plus a shift-register window,
// emitting one registered window per accepted pixel that completes one.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int CL_IN  = 8,
  parameter int KERNEL = 3,
  parameter int N      = 2,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);
  localparam int PIX_W = CL_IN * N;
  localparam int WIN_W = CL_IN * KERNEL * KERNEL * N;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, cur_col;
  logic [RW-1:0]   row, row_nxt, cur_row;
  logic            accept, win_hit, last_pix, err_nxt;
  logic [PIX_W-1:0] tap_col [KERNEL];
  logic [WIN_W-1:0] win, win_nxt, data_q;
  logic            en_q, done_q, err_q;

  // tap_col[0] is the current pixel, tap_col[j] the same column j rows up.
  assign tap_col[0] = bus.pix_in;

  for (genvar j = 0; j < KERNEL - 1; j++) begin : g_line
    conv_window_gen_row_delay_line #(
      .W     (PIX_W),
      .DEPTH (IMG_W)
    ) u_line (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (tap_col[j]),
      .dout (tap_col[j+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      row    <= '0;
      col    <= '0;
      win    <= '0;
      data_q <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      row    <= row_nxt;
      col    <= col_nxt;
      win    <= win_nxt;
      en_q   <= win_hit;
      done_q <= last_pix;
      err_q  <= err_nxt;
      if (win_hit) data_q <= win_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    cur_row   = row;
    cur_col   = col;
    accept    = 1'b0;
    win_hit   = 1'b0;
    last_pix  = 1'b0;
    err_nxt   = 1'b0;

    // sof restarts the frame from any state; without it only an open frame accepts.
    if (bus.pix_valid) begin
      if (bus.sof) begin
        accept  = 1'b1;
        cur_row = '0;
        cur_col = '0;
      end else if (state == ST_IDLE) begin
        err_nxt = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end

    if (accept) begin
      win_hit  = (int'(cur_row) >= KERNEL - 1) && (int'(cur_col) >= KERNEL - 1);
      last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
      if (last_pix) begin
        state_nxt = ST_IDLE;
        row_nxt   = '0;
        col_nxt   = '0;
      end else begin
        if (cur_col == CW'(IMG_W - 1)) begin
          col_nxt = '0;
          row_nxt = cur_row + 1'b1;
        end else begin
          col_nxt = cur_col + 1'b1;
          row_nxt = cur_row;
        end
        state_nxt = (int'(row_nxt) >= KERNEL - 1) ? ST_RUN : ST_FILL;
      end
    end
  end

  // Window columns shift left; the new right column is oldest row on top.
  always_comb begin
    win_nxt = win;
    if (accept) begin
      for (int ch = 0; ch < CL_IN; ch++) begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL; c++) begin
            if (c < KERNEL - 1)
              win_nxt[tap_offset(ch, r, c, KERNEL, N) +: N] =
                win[tap_offset(ch, r, c + 1, KERNEL, N) +: N];
            else
              win_nxt[tap_offset(ch, r, c, KERNEL, N) +: N] =
                tap_col[KERNEL-1-r][ch*N +: N];
          end
        end
      end
    end
  end

  assign bus.data2conv  = data_q;
  assign bus.en_out     = en_q;
  assign bus.frame_done = done_q;
  assign bus.sof_err    = err_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised self-checking bench: a position/image model predicts every
// window, frame_done and sof_err, compared against two DUTs (K=3 and K=1).
module tb_conv_window_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.CL_IN(2), .KERNEL(3), .N(2)) i3 ();
  conv_window_gen_if #(.CL_IN(2), .KERNEL(1), .N(2)) i1 ();

  conv_window_gen #(.CL_IN(2), .KERNEL(3), .N(2), .IMG_W(5), .IMG_H(4)) dut3 (
    .clk (clk), .rst (rst), .bus (i3.slave));
  conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(2), .IMG_W(2), .IMG_H(2)) dut1 (
    .clk (clk), .rst (rst), .bus (i1.slave));

  int checks = 0;
  int errors = 0;

  logic        exp_en   [2];
  logic        exp_fd   [2];
  logic        exp_err  [2];
  logic [63:0] exp_data [2];
  bit          m_in [2];
  int          m_r  [2];
  int          m_c  [2];
  logic [3:0]  img  [2][8][8];
  logic [1:0]  ch1tab [4][5];
  logic [35:0] first_win;
  bit          want_first = 1'b0;
  int          win_cnt [2] = '{0, 0};
  int          fd_cnt  [2] = '{0, 0};
  int          err_cnt [2] = '{0, 0};

  function automatic int kk(input int d); return (d == 1) ? 1 : 3; endfunction
  function automatic int ww(input int d); return (d == 1) ? 2 : 5; endfunction
  function automatic int hh(input int d); return (d == 1) ? 2 : 4; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_en[d] = 1'b0; exp_fd[d] = 1'b0; exp_err[d] = 1'b0;
      exp_data[d] = '0; m_in[d] = 1'b0; m_r[d] = 0; m_c[d] = 0;
    end
  endtask

  // Outputs expected in the cycle after an accepting edge.
  task automatic model_step(input int d, input bit v, input bit s, input logic [3:0] pix);
    int k;
    logic [63:0] w;
    k = kk(d);
    if (!v) return;
    if (s) begin
      m_in[d] = 1'b1; m_r[d] = 0; m_c[d] = 0;
    end else if (!m_in[d]) begin
      exp_err[d] = 1'b1;
      return;
    end
    img[d][m_r[d]][m_c[d]] = pix;
    if (m_r[d] >= k - 1 && m_c[d] >= k - 1) begin
      w = '0;
      for (int ch = 0; ch < 2; ch++)
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            w[((ch * k + r) * k + c) * 2 +: 2] =
              img[d][m_r[d] - k + 1 + r][m_c[d] - k + 1 + c][ch*2 +: 2];
      exp_en[d]   = 1'b1;
      exp_data[d] = w;
      if (d == 0 && want_first) begin
        first_win  = w[35:0];
        want_first = 1'b0;
      end
    end
    if (m_r[d] == hh(d) - 1 && m_c[d] == ww(d) - 1) begin
      exp_fd[d] = 1'b1;
      m_in[d]   = 1'b0;
    end else if (m_c[d] == ww(d) - 1) begin
      m_c[d] = 0;
      m_r[d]++;
    end else begin
      m_c[d]++;
    end
  endtask

  always @(negedge clk) begin
    check("en_out k3",     64'(i3.en_out),     64'(exp_en[0]));
    check("frame_done k3", 64'(i3.frame_done), 64'(exp_fd[0]));
    check("sof_err k3",    64'(i3.sof_err),    64'(exp_err[0]));
    check("data2conv k3",  64'(i3.data2conv),  exp_data[0]);
    check("en_out k1",     64'(i1.en_out),     64'(exp_en[1]));
    check("frame_done k1", 64'(i1.frame_done), 64'(exp_fd[1]));
    check("sof_err k1",    64'(i1.sof_err),    64'(exp_err[1]));
    check("data2conv k1",  64'(i1.data2conv),  exp_data[1]);
    if (i3.en_out === 1'b1)     win_cnt[0]++;
    if (i3.frame_done === 1'b1) fd_cnt[0]++;
    if (i3.sof_err === 1'b1)    err_cnt[0]++;
    if (i1.en_out === 1'b1)     win_cnt[1]++;
    if (i1.frame_done === 1'b1) fd_cnt[1]++;
    for (int d = 0; d < 2; d++) begin
      exp_en[d] = 1'b0; exp_fd[d] = 1'b0; exp_err[d] = 1'b0;
    end
  end

  function automatic logic [3:0] pixv(input int r, input int c);
    return {ch1tab[r][c], 2'((r * 5 + c) % 4)};
  endfunction

  task automatic clear_inputs();
    i3.pix_valid = 1'b0; i3.sof = 1'b0; i3.pix_in = '0;
    i1.pix_valid = 1'b0; i1.sof = 1'b0; i1.pix_in = '0;
  endtask

  task automatic send(input int d, input bit v, input bit s, input logic [3:0] pix);
    if (d == 0) begin
      i3.pix_valid = v; i3.sof = s; i3.pix_in = pix;
    end else begin
      i1.pix_valid = v; i1.sof = s; i1.pix_in = pix;
    end
    @(posedge clk);
    model_step(d, v, s, pix);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic randomize_tab();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        ch1tab[r][c] = 2'($urandom_range(0, 3));
  endtask

  task automatic frame(input int d, input int gap_mode);
    for (int r = 0; r < hh(d); r++)
      for (int c = 0; c < ww(d); c++) begin
        send(d, 1'b1, (r == 0 && c == 0), pixv(r, c));
        if (gap_mode == 1) idle(1);
        else if (gap_mode == 2) idle($urandom_range(0, 2));
      end
  endtask

  task automatic expect_counts(input string name, input int d, input int w0, input int f0,
                               input int nwin, input int nfd);
    check({name, " windows"},    64'(win_cnt[d] - w0), 64'(nwin));
    check({name, " frame_done"}, 64'(fd_cnt[d] - f0),  64'(nfd));
  endtask

  initial begin
    int w0, f0, e0;
    int lit [9] = '{0, 1, 2, 1, 2, 3, 2, 3, 0};
    logic [17:0] lit_v;

    clear_inputs();
    model_reset();
    randomize_tab();
    #1 rst = 1'b0;
    idle(2);
    check("reset en_out",     64'(i3.en_out),     64'd0);
    check("reset data2conv",  64'(i3.data2conv),  64'd0);
    check("reset frame_done", 64'(i3.frame_done), 64'd0);
    check("reset sof_err",    64'(i3.sof_err),    64'd0);
    rst = 1'b1;
    idle(1);

    // Continuous frame
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    want_first = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        send(0, 1'b1, (r == 0 && c == 0), pixv(r, c));
        if (r == 2 && c == 1) check("latency before (2,2)", 64'(i3.en_out), 64'd0);
        if (r == 2 && c == 2) check("latency after (2,2)",  64'(i3.en_out), 64'd1);
      end
    idle(3);
    expect_counts("continuous", 0, w0, f0, 6, 1);
    for (int i = 0; i < 9; i++) lit_v[2*i +: 2] = 2'(lit[i]);
    check("model first window ch0", 64'(first_win[17:0]), 64'(lit_v));

    // Same frame, pix_valid low every other cycle
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    frame(0, 1);
    idle(3);
    expect_counts("gapped", 0, w0, f0, 6, 1);

    // Two pixels without sof while idle, then a normal frame
    w0 = win_cnt[0]; f0 = fd_cnt[0]; e0 = err_cnt[0];
    send(0, 1'b1, 1'b0, 4'h5);
    idle(1);
    send(0, 1'b1, 1'b0, 4'hA);
    idle(2);
    check("sof_err pulses", 64'(err_cnt[0] - e0), 64'd2);
    frame(0, 0);
    idle(3);
    expect_counts("after sof_err", 0, w0, f0, 6, 1);

    // sof re-asserted at pixel (2,1)
    randomize_tab();
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    for (int p = 0; p < 11; p++)
      send(0, 1'b1, (p == 0), pixv(p / 5, p % 5));
    frame(0, 0);
    idle(3);
    expect_counts("abort", 0, w0, f0, 6, 1);

    // Reset asserted while pixel (3,0) is presented
    for (int p = 0; p < 15; p++)
      send(0, 1'b1, (p == 0), pixv(p / 5, p % 5));
    i3.pix_valid = 1'b1; i3.pix_in = pixv(3, 0);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("async reset en_out",    64'(i3.en_out),    64'd0);
    check("async reset data2conv", 64'(i3.data2conv), 64'd0);
    clear_inputs();
    idle(2);
    rst = 1'b1;
    w0 = win_cnt[0]; f0 = fd_cnt[0];
    frame(0, 0);
    idle(3);
    expect_counts("after reset", 0, w0, f0, 6, 1);

    // KERNEL=1 pass-through
    w0 = win_cnt[1]; f0 = fd_cnt[1];
    frame(1, 0);
    idle(3);
    expect_counts("kernel1", 1, w0, f0, 4, 1);

    // Randomised gaps with fresh channel-1 data
    for (int n = 0; n < 3; n++) begin
      randomize_tab();
      w0 = win_cnt[0]; f0 = fd_cnt[0];
      frame(0, 2);
      idle($urandom_range(1, 4));
      expect_counts("random gaps", 0, w0, f0, 6, 1);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
